// File: rtl/trng_sched_pkg.sv
// Shared state encoding and counter-width helpers for the TRNG scheduler.
package trng_sched_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StOff     = 3'd0;
  localparam state_t StWarmup  = 3'd1;
  localparam state_t StDiscard = 3'd2;
  localparam state_t StReady   = 3'd3;
  localparam state_t StAck     = 3'd4;

  // Bits needed to count 0..max_val inclusive, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned warm_cnt_w(input int unsigned warmup_keys);
    return cnt_width(warmup_keys);
  endfunction

  function automatic int unsigned to_cnt_w(input int unsigned timeout_cycles);
    return cnt_width(timeout_cycles);
  endfunction

endpackage

// File: rtl/trng_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot winner, pointer advances past the winner on adv_i.
module trng_rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] req_i,
  input  logic             adv_i,
  output logic [N_REQ-1:0] win_o,
  output logic [PtrW-1:0]  ptr_o
);

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] idx;
  logic [PtrW-1:0] win_idx;
  logic            found;

  always_comb begin
    win_o   = '0;
    win_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = PtrW'((32'(ptr_q) + i) % N_REQ);
      if (!found && req_i[idx]) begin
        win_o[idx] = 1'b1;
        win_idx    = idx;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && found) begin
      ptr_d = PtrW'((32'(win_idx) + 1) % N_REQ);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/trng_sched.sv
// TRNG core sequencer: warm-up discard, round-robin key sharing, timeout watch.
// Define TRNG_SCHED_REPCOUNT_EN to add the repetition-count health test.
module trng_sched
  import trng_sched_pkg::*;
#(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned N_BITS_KEY     = 32,
  parameter int unsigned WARMUP_KEYS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [N_REQ-1:0]      req_i,
  output logic [N_REQ-1:0]      gnt_o,
  output logic [N_BITS_KEY-1:0] key_o,
  output logic                  trng_enable_o,
  output logic                  trng_ack_read_o,
  input  logic                  trng_key_ready_i,
  input  logic [N_BITS_KEY-1:0] trng_key_i,
  output logic                  warm_o,
  output logic                  timeout_o,
  output logic                  health_fail_o
);

  localparam int unsigned WarmW = warm_cnt_w(WARMUP_KEYS);
  localparam int unsigned ToW   = to_cnt_w(TIMEOUT_CYCLES);
  localparam int unsigned PtrW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [WarmW-1:0] WarmMax = WarmW'(WARMUP_KEYS);
  localparam logic [ToW-1:0]   ToMax   = ToW'(TIMEOUT_CYCLES);

  state_t                  state_q, state_d;
  logic [WarmW-1:0]        warm_cnt_q, warm_cnt_d, warm_inc;
  logic [ToW-1:0]          to_cnt_q, to_cnt_d, to_inc;
  logic [N_BITS_KEY-1:0]   key_q, key_d;
  logic [N_REQ-1:0]        gnt_q, gnt_d;
  logic                    timeout_q, timeout_d;
  logic [N_REQ-1:0]        arb_win;
  logic [PtrW-1:0]         arb_ptr;
  logic                    arb_adv;
  logic                    any_req;
  logic                    rep_hit;

  assign any_req  = |req_i;
  assign warm_inc = warm_cnt_q + 1'b1;
  assign to_inc   = to_cnt_q + 1'b1;

  trng_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req_i),
    .adv_i  (arb_adv),
    .win_o  (arb_win),
    .ptr_o  (arb_ptr)
  );

  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    to_cnt_d   = to_cnt_q;
    key_d      = key_q;
    gnt_d      = '0;
    timeout_d  = timeout_q;
    arb_adv    = 1'b0;

    if (trng_key_ready_i) begin
      to_cnt_d = '0;
    end else if ((state_q == StWarmup) || ((state_q == StReady) && any_req)) begin
      if (to_cnt_q != ToMax) begin
        to_cnt_d = to_inc;
        if (to_inc == ToMax) timeout_d = 1'b1;
      end
    end

    case (state_q)
      StOff: begin
        warm_cnt_d = '0;
        to_cnt_d   = '0;
        if (en_i) state_d = (WARMUP_KEYS == 0) ? StReady : StWarmup;
      end
      StWarmup: begin
        if (!en_i) state_d = StOff;
        else if (trng_key_ready_i) state_d = StDiscard;
      end
      StDiscard: begin
        // A counter already at WarmMax means a health-test rejection, not warm-up.
        if (!trng_key_ready_i) begin
          if (warm_cnt_q != WarmMax) warm_cnt_d = warm_inc;
          if (!en_i) state_d = StOff;
          else if ((warm_cnt_q == WarmMax) || (warm_inc == WarmMax)) state_d = StReady;
          else state_d = StWarmup;
        end
      end
      StReady: begin
        if (!en_i) begin
          state_d = StOff;
        end else if (trng_key_ready_i && any_req) begin
          if (rep_hit) begin
            state_d = StDiscard;
          end else begin
            state_d = StAck;
            key_d   = trng_key_i;
            gnt_d   = arb_win;
            arb_adv = 1'b1;
          end
        end
      end
      StAck: begin
        if (!trng_key_ready_i) state_d = en_i ? StReady : StOff;
      end
      default: state_d = StOff;
    endcase

    if (state_d == StOff) timeout_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StOff;
      warm_cnt_q <= '0;
      to_cnt_q   <= '0;
      key_q      <= '0;
      gnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      to_cnt_q   <= to_cnt_d;
      key_q      <= key_d;
      gnt_q      <= gnt_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef TRNG_SCHED_REPCOUNT_EN
  logic [N_BITS_KEY-1:0] prev_key_q, prev_key_d;
  logic                  health_q, health_d;
  logic                  key_take;

  assign rep_hit  = (trng_key_i == prev_key_q);
  assign key_take = trng_key_ready_i && en_i &&
                    ((state_q == StWarmup) || ((state_q == StReady) && any_req));

  always_comb begin
    prev_key_d = prev_key_q;
    health_d   = health_q;
    if (key_take) begin
      prev_key_d = trng_key_i;
      if (rep_hit) health_d = 1'b1;
    end
    if (state_d == StOff) health_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_key_q <= '0;
      health_q   <= 1'b0;
    end else begin
      prev_key_q <= prev_key_d;
      health_q   <= health_d;
    end
  end

  assign health_fail_o = health_q;
`else
  assign rep_hit       = 1'b0;
  assign health_fail_o = 1'b0;
`endif

  assign gnt_o           = gnt_q;
  assign key_o           = key_q;
  assign trng_enable_o   = (state_q != StOff);
  assign trng_ack_read_o = (state_q == StDiscard) || (state_q == StAck);
  assign warm_o          = (state_q == StReady) || (state_q == StAck);
  assign timeout_o       = timeout_q;

endmodule
